mesh_route_node: RTL

Parametrised 4-port mesh router node for the pckg_sz-bit packet network driven by the mesh testbench environment. Each port has an input FIFO fed by the upstream pndng/pop handshake and a one-entry output register drained by the downstream consumer. Heads are routed by dimension-order on the destination row/column (row-first or column-first, per packet or forced by parameter), with per-output round-robin arbitration and next-jump rewriting. It is the building block of the next-generation mesh, replacing the fixed-mode node.

---
 rtl/mesh_route_node.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mesh_route_node.sv
// 4-port dimension-order mesh router node: per-input FIFOs, one-entry output
// registers, per-output round-robin arbitration and next-jump rewriting.
module mesh_route_node #(
   parameter int pckg_sz    = 40,
   parameter int fifo_depth = 4,
   parameter int ID_ROW     = 1,
   parameter int ID_COL     = 1,
   parameter int MODE_CFG   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4*pckg_sz-1:0] data_out_i_in,
   input  logic [3:0]           pndng_i_in,
   output logic [3:0]           popin,
   output logic [4*pckg_sz-1:0] data_out,
   output logic [3:0]           pndng,
   input  logic [3:0]           pop,
   output logic                 drop,
   output logic [15:0]          drop_cnt
);
   localparam int CW = $clog2(fifo_depth + 1);
   localparam int PW = $clog2(fifo_depth);
   localparam logic [3:0] MY_ROW = 4'(ID_ROW);
   localparam logic [3:0] MY_COL = 4'(ID_COL);

   logic [3:0][fifo_depth-1:0][pckg_sz-1:0] mem_q;
   logic [3:0][PW-1:0]                      rd_q, wr_q;
   logic [3:0][CW-1:0]                      cnt_q;
   logic [3:0][pckg_sz-1:0]                 out_q;
   logic [3:0]                              pndng_q;
   logic [3:0][1:0]                         rr_q;
   logic                                    drop_q;
   logic [15:0]                             drop_cnt_q, drop_cnt_d;

   logic [3:0][pckg_sz-1:0] din, head;
   logic [3:0][2:0]         rt;
   logic [3:0]              hv, self_hd, deq, free, gnt_vld;
   logic [3:0][3:0]         req;
   logic [3:0][1:0]         gnt_idx;
   logic [16:0]             drop_sum;

   // Returns {self, dir}; dir: 0=N 1=S 2=E 3=W.
   function automatic logic [2:0] route(input logic [pckg_sz-1:0] pkt);
      logic [3:0] dr, dc;
      logic       rf, row_hit, col_hit;
      logic [1:0] rdir, cdir;
      dr      = pkt[pckg_sz-9 -: 4];
      dc      = pkt[pckg_sz-13 -: 4];
      rf      = (MODE_CFG == 1) ? 1'b1 : (MODE_CFG == 2) ? 1'b0 : pkt[pckg_sz-17];
      rdir    = (dr < MY_ROW) ? 2'd0 : 2'd1;
      cdir    = (dc > MY_COL) ? 2'd2 : 2'd3;
      row_hit = (dr == MY_ROW);
      col_hit = (dc == MY_COL);
      if (row_hit && col_hit) return 3'b100;
      else if (rf)            return {1'b0, row_hit ? cdir : rdir};
      else                    return {1'b0, col_hit ? rdir : cdir};
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      return (ptr == PW'(fifo_depth - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign din      = data_out_i_in;
   assign data_out = out_q;
   assign pndng    = pndng_q;
   assign drop     = drop_q;
   assign drop_cnt = drop_cnt_q;

   always_comb begin
      popin   = '0;
      head    = '0;
      hv      = '0;
      rt      = '0;
      self_hd = '0;
      req     = '0;
      free    = '0;
      for (int p = 0; p < 4; p++) begin
         popin[p]   = pndng_i_in[p] & ~reset & (cnt_q[p] < CW'(fifo_depth));
         head[p]    = mem_q[p][rd_q[p]];
         hv[p]      = (cnt_q[p] != '0);
         rt[p]      = route(head[p]);
         self_hd[p] = hv[p] & rt[p][2];
         req[rt[p][1:0]][p] = hv[p] & ~rt[p][2];
         free[p]    = ~pndng_q[p] | pop[p];
      end
   end

   // First requester at or after rr[o], scanning cyclically.
   always_comb begin
      gnt_vld = '0;
      gnt_idx = '0;
      for (int o = 0; o < 4; o++) begin
         gnt_idx[o] = rr_q[o];
         for (int k = 0; k < 4; k++) begin
            if (free[o] && !gnt_vld[o] && req[o][rr_q[o] + 2'(k)]) begin
               gnt_vld[o] = 1'b1;
               gnt_idx[o] = rr_q[o] + 2'(k);
            end
         end
      end
   end

   always_comb begin
      deq = '0;
      for (int p = 0; p < 4; p++)
         deq[p] = self_hd[p] |
                  (hv[p] & gnt_vld[rt[p][1:0]] & (gnt_idx[rt[p][1:0]] == 2'(p)));
      drop_sum   = {1'b0, drop_cnt_q} + 17'($countones(self_hd));
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q      <= '0;
         rd_q       <= '0;
         wr_q       <= '0;
         cnt_q      <= '0;
         out_q      <= '0;
         pndng_q    <= '0;
         rr_q       <= '0;
         drop_q     <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         for (int p = 0; p < 4; p++) begin
            if (popin[p]) begin
               mem_q[p][wr_q[p]] <= din[p];
               wr_q[p]           <= ptr_inc(wr_q[p]);
            end
            if (deq[p]) rd_q[p] <= ptr_inc(rd_q[p]);
            cnt_q[p] <= cnt_q[p] + CW'(popin[p]) - CW'(deq[p]);
         end
         for (int o = 0; o < 4; o++) begin
            if (gnt_vld[o]) begin
               out_q[o]   <= {MY_ROW, MY_COL, head[gnt_idx[o]][pckg_sz-9:0]};
               pndng_q[o] <= 1'b1;
               rr_q[o]    <= gnt_idx[o] + 2'd1;
            end else if (pop[o]) begin
               pndng_q[o] <= 1'b0;
            end
         end
         drop_q     <= |self_hd;
         drop_cnt_q <= drop_cnt_d;
      end
   end
endmodule
